// File: rtl/csa63_accum_ctrl.sv
// Multi-operand summing controller: a 6:3 compressor row accumulates beats into three redundant rows, which are resolved to one sum on the last beat.
// Optional macro CSA63_PIPE_RESOLVE_EN splits the resolve step into a 3:2 stage followed by a 2-input add.
module csa63_accum_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MAX_OPS = 64,
  parameter int CW      = $clog2(MAX_OPS + 1),
  parameter int ACC_W   = WIDTH + $clog2(MAX_OPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*WIDTH-1:0] in_data,
  input  logic [1:0]         in_cnt,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CW-1:0]      out_ops,
  output logic               out_ovf,
  output logic               busy
);

  if (ACC_W < WIDTH + $clog2(MAX_OPS)) begin : g_acc_w_chk
    $error("csa63_accum_ctrl: ACC_W too small for WIDTH/MAX_OPS");
  end

`ifdef CSA63_PIPE_RESOLVE_EN
  typedef enum logic [2:0] {IDLE, ACCUM, RES1, RES2, OUTPUT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;
`endif

  state_t state, state_n;

  logic             acc;
  logic [ACC_W-1:0] r0, r1, r2;
  logic [ACC_W-1:0] op0, op1, op2;
  logic [ACC_W-1:0] cs, cc, cc1;
  logic [2:0]       col;
  logic [CW+1:0]    cnt_sum;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ovf, ovf_n;
`ifdef CSA63_PIPE_RESOLVE_EN
  logic [ACC_W-1:0] p0, p1, maj;
`endif

  assign in_ready = rst_n && (state == IDLE || state == ACCUM);
  assign acc      = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // unused operand slots are forced to zero
  always_comb begin
    op0 = '0;
    op1 = '0;
    op2 = '0;
    if (in_cnt >= 2'd1) op0 = ACC_W'(in_data[0*WIDTH +: WIDTH]);
    if (in_cnt >= 2'd2) op1 = ACC_W'(in_data[1*WIDTH +: WIDTH]);
    if (in_cnt == 2'd3) op2 = ACC_W'(in_data[2*WIDTH +: WIDTH]);
  end

  always_comb begin
    cs  = '0;
    cc  = '0;
    cc1 = '0;
    col = '0;
    for (int i = 0; i < ACC_W; i++) begin
      col = 3'(r0[i]) + 3'(r1[i]) + 3'(r2[i])
          + 3'(op0[i]) + 3'(op1[i]) + 3'(op2[i]);
      cs[i]  = col[0];
      cc[i]  = col[1];
      cc1[i] = col[2];
    end
  end

  assign cnt_sum = (CW+2)'(cnt) + (CW+2)'(in_cnt);
  assign ovf_n   = cnt_sum > (CW+2)'(MAX_OPS);
  assign cnt_n   = ovf_n ? CW'(MAX_OPS) : cnt_sum[CW-1:0];

`ifdef CSA63_PIPE_RESOLVE_EN
  assign maj = (r0 & r1) | (r0 & r2) | (r1 & r2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (acc) begin
`ifdef CSA63_PIPE_RESOLVE_EN
          state_n = in_last ? RES1 : ACCUM;
`else
          state_n = in_last ? RESOLVE : ACCUM;
`endif
        end
      end
      ACCUM: begin
        if (acc && in_last) begin
`ifdef CSA63_PIPE_RESOLVE_EN
          state_n = RES1;
`else
          state_n = RESOLVE;
`endif
        end
      end
`ifdef CSA63_PIPE_RESOLVE_EN
      RES1:    state_n = RES2;
      RES2:    state_n = OUTPUT;
`else
      RESOLVE: state_n = OUTPUT;
`endif
      OUTPUT: begin
        if (out_valid && out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_ops   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
`ifdef CSA63_PIPE_RESOLVE_EN
      p0        <= '0;
      p1        <= '0;
`endif
    end else begin
      if (acc) begin
        r0  <= cs;
        r1  <= {cc[ACC_W-2:0], 1'b0};
        r2  <= {cc1[ACC_W-3:0], 2'b00};
        cnt <= cnt_n;
        ovf <= ovf | ovf_n;
      end
`ifdef CSA63_PIPE_RESOLVE_EN
      if (state == RES1) begin
        p0      <= r0 ^ r1 ^ r2;
        p1      <= {maj[ACC_W-2:0], 1'b0};
        out_ops <= cnt;
        out_ovf <= ovf;
        r0      <= '0;
        r1      <= '0;
        r2      <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end
      if (state == RES2) out_sum <= p0 + p1;
`else
      if (state == RESOLVE) begin
        out_sum <= r0 + r1 + r2;
        out_ops <= cnt;
        out_ovf <= ovf;
        r0      <= '0;
        r1      <= '0;
        r2      <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end
`endif
      // valid rises one cycle into OUTPUT, drops on the handshake
      if (state == OUTPUT) begin
        if (!out_valid)     out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule
